// File: rtl/mul_hilo_pkg.sv
// mul_hilo_pkg
// Shared types for the HI/LO accumulator behind the pipelined multiplier:
//   mul_op_t            - write-back operation carried with each issued multiply
//   tag_t               - {valid, op} tag that travels alongside the product
//   MUL_LATENCY_DEFAULT - default multiplier latency in cycles
package mul_hilo_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2,
    OP_RSVD = 2'd3
  } mul_op_t;

  localparam int MUL_LATENCY_DEFAULT = 2;

  typedef struct packed {
    logic    valid;
    mul_op_t op;
  } tag_t;

endpackage

// File: rtl/mul_hilo_accumulator_tag_delay.sv
// mul_tag_delay
// Shift register of multiply tags, STAGES deep, so that a tag leaves the last
// stage in the same cycle the matching product leaves the multiplier.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (clears every stage)
//   tag_in    - tag captured into stage 0 at each edge
//   tag_out   - tag in the final stage
//   vld       - valid bit of every stage, for the busy indication
module mul_tag_delay
  import mul_hilo_pkg::*;
#(
  parameter int STAGES = MUL_LATENCY_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  tag_t              tag_in,
  output tag_t              tag_out,
  output logic [STAGES-1:0] vld
);

  tag_t tag_p [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        tag_p[i] <= '0;
      end
    end else begin
      tag_p[0] <= tag_in;
      for (int i = 1; i < STAGES; i++) begin
        tag_p[i] <= tag_p[i-1];
      end
    end
  end

  always_comb begin
    vld = '0;
    for (int i = 0; i < STAGES; i++) begin
      vld[i] = tag_p[i].valid;
    end
  end

  assign tag_out = tag_p[STAGES-1];

endmodule

// File: rtl/mul_hilo_accumulator.sv
// mul_hilo_accumulator
// Architectural HI/LO pair fed by a MUL_LATENCY-cycle pipelined multiplier.
// Each issued multiply carries a tag down a matching delay line; when the tag
// reaches the end, the product is loaded into, added to or subtracted from
// {hi,lo}. MTHI/MTLO writes are dropped when they collide with a write-back.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   issue_valid/op      - multiply issued this cycle and its write-back op
//   product             - multiplier output (2*WIDTH)
//   mthi_en/mtlo_en     - direct writes of wdata into hi/lo
//   hi, lo              - architectural registers
//   busy                - a multiply is in flight (or being issued now)
//   wb_pulse            - one cycle after each LOAD/ADD/SUB write-back
//   ovf                 - sticky signed overflow of ADD/SUB
// Build option: define MULHILO_OVF_EN to enable ovf tracking and the
// MT-while-busy assertion; otherwise ovf is tied low.
module mul_hilo_accumulator
  import mul_hilo_pkg::*;
#(
  parameter int MUL_LATENCY = MUL_LATENCY_DEFAULT,
  parameter int WIDTH       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               issue_valid,
  input  logic [1:0]         issue_op,
  input  logic [2*WIDTH-1:0] product,
  input  logic               mthi_en,
  input  logic               mtlo_en,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               busy,
  output logic               wb_pulse,
  output logic               ovf
);

  localparam int PW = 2 * WIDTH;

  function automatic logic [PW-1:0] hilo_next(input logic [PW-1:0] acc,
                                              input logic [PW-1:0] prod,
                                              input mul_op_t       op);
    case (op)
      OP_LOAD: return prod;
      OP_ADD:  return acc + prod;
      OP_SUB:  return acc - prod;
      default: return acc;
    endcase
  endfunction

  tag_t              tag_in;
  tag_t              tag_fin;
  logic [MUL_LATENCY-1:0] tag_vld;
  logic              wb_en;
  logic [PW-1:0]     hilo_cur;
  logic [PW-1:0]     hilo_nxt;

  assign tag_in.valid = issue_valid;
  assign tag_in.op    = mul_op_t'(issue_op);

  // Tag delay: tag_fin lines up with the product on the multiplier output
  mul_tag_delay #(
    .STAGES (MUL_LATENCY)
  ) u_tag_delay (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_fin),
    .vld     (tag_vld)
  );

  assign busy     = issue_valid | (|tag_vld);
  assign wb_en    = tag_fin.valid && (tag_fin.op != OP_RSVD);
  assign hilo_cur = {hi, lo};
  assign hilo_nxt = hilo_next(hilo_cur, product, tag_fin.op);

  // Write-back stage: product into {hi,lo}; write-back takes priority over MT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi       <= '0;
      lo       <= '0;
      wb_pulse <= 1'b0;
    end else begin
      wb_pulse <= wb_en;
      if (wb_en) begin
        {hi, lo} <= hilo_nxt;
      end else begin
        if (mthi_en) hi <= wdata;
        if (mtlo_en) lo <= wdata;
      end
    end
  end

`ifdef MULHILO_OVF_EN
  function automatic logic add_sub_ovf(input logic [PW-1:0] acc,
                                       input logic [PW-1:0] prod,
                                       input logic [PW-1:0] res,
                                       input mul_op_t       op);
    logic signed [PW-1:0] s_acc;
    logic signed [PW-1:0] s_prod;
    logic signed [PW-1:0] s_res;
    s_acc  = $signed(acc);
    s_prod = $signed(prod);
    s_res  = $signed(res);
    case (op)
      OP_ADD:  return ((s_acc < 0) == (s_prod < 0)) && ((s_res < 0) != (s_acc < 0));
      OP_SUB:  return ((s_acc < 0) != (s_prod < 0)) && ((s_res < 0) != (s_acc < 0));
      default: return 1'b0;
    endcase
  endfunction

  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (wb_en) begin
      if (tag_fin.op == OP_LOAD) begin
        ovf_q <= 1'b0;
      end else if (add_sub_ovf(hilo_cur, product, hilo_nxt, tag_fin.op)) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign ovf = ovf_q;

  // MTHI/MTLO while a product is in flight is a CPU protocol violation
  a_mt_not_busy: assert property (@(posedge clk) disable iff (rst)
                                  !((mthi_en || mtlo_en) && busy));
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mul_hilo_accumulator.sv
// Testbench for mul_hilo_accumulator: directed cases followed by randomized
// traffic, compared against a queue-based reference model of in-flight
// multiplies.
module tb_mul_hilo_accumulator;

  localparam int W = 32;
  localparam int L = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_valid;
  logic [1:0]      issue_op;
  logic [2*W-1:0]  product;
  logic            mthi_en;
  logic            mtlo_en;
  logic [W-1:0]    wdata;
  logic [W-1:0]    hi;
  logic [W-1:0]    lo;
  logic            busy;
  logic            wb_pulse;
  logic            ovf;

  always #5 clk = ~clk;

  mul_hilo_accumulator #(
    .MUL_LATENCY (L),
    .WIDTH       (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_op    (issue_op),
    .product     (product),
    .mthi_en     (mthi_en),
    .mtlo_en     (mtlo_en),
    .wdata       (wdata),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .wb_pulse    (wb_pulse),
    .ovf         (ovf)
  );

  typedef struct {
    int          due;
    logic [1:0]  op;
    logic [63:0] p;
  } pend_t;

  pend_t       pq[$];
  logic [63:0] m_hilo;
  logic        m_wb;
  logic        m_ovf;
  int          cyc;
  int          n_chk;
  int          n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_outputs();
    chk("hi", hi, m_hilo[63:32]);
    chk("lo", lo, m_hilo[31:0]);
    chk("wb_pulse", wb_pulse, m_wb);
    chk("ovf", ovf, m_ovf);
  endtask

  // One clock cycle: apply inputs, check busy, advance model, check state.
  task automatic step(input logic iv, input logic [1:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic mh, input logic ml, input logic [31:0] wd);
    logic [63:0]        nxt;
    logic               wb;
    logic signed [65:0] wide;
    pend_t              e;
    issue_valid = iv;
    issue_op    = op;
    mthi_en     = mh;
    mtlo_en     = ml;
    wdata       = wd;
    if (pq.size() > 0 && pq[0].due == cyc) product = pq[0].p;
    else product = {$urandom(), $urandom()};
    #1;
    chk("busy", busy, (pq.size() > 0) || iv);
    wb   = 1'b0;
    nxt  = m_hilo;
    wide = '0;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      e = pq.pop_front();
      if (e.op != 2'd3) begin
        wb = 1'b1;
        case (e.op)
          2'd0: nxt = e.p;
          2'd1: begin
            nxt  = m_hilo + e.p;
            wide = 66'($signed(m_hilo)) + 66'($signed(e.p));
          end
          default: begin
            nxt  = m_hilo - e.p;
            wide = 66'($signed(m_hilo)) - 66'($signed(e.p));
          end
        endcase
`ifdef MULHILO_OVF_EN
        if (e.op == 2'd0) m_ovf = 1'b0;
        else if (wide != 66'($signed(nxt))) m_ovf = 1'b1;
`endif
      end
    end
    if (!wb) begin
      if (mh) nxt[63:32] = wd;
      if (ml) nxt[31:0]  = wd;
    end
    if (iv) pq.push_back('{due: cyc + L, op: op, p: 64'(a) * 64'(b)});
    m_hilo = nxt;
    m_wb   = wb;
    @(posedge clk);
    #1;
    cyc++;
    chk_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  // Reset asserted asynchronously between edges, held across one edge.
  task automatic do_reset();
    issue_valid = 1'b0;
    mthi_en     = 1'b0;
    mtlo_en     = 1'b0;
    rst         = 1'b1;
    pq.delete();
    m_hilo = '0;
    m_wb   = 1'b0;
    m_ovf  = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
  endtask

  initial begin
    int r;
    n_chk = 0;
    n_err = 0;
    cyc   = 0;
    rst   = 1'b1;
    issue_valid = 1'b0;
    issue_op    = 2'd0;
    product     = '0;
    mthi_en     = 1'b0;
    mtlo_en     = 1'b0;
    wdata       = '0;
    m_hilo = '0;
    m_wb   = 1'b0;
    m_ovf  = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // LOAD 3*5
    step(1'b1, 2'd0, 32'd3, 32'd5, 1'b0, 1'b0, 32'd0);
    idle(2);
    chk("t1_lo", lo, 64'd15);
    chk("t1_hi", hi, 64'd0);
    chk("t1_wb", wb_pulse, 1'b1);
    idle(1);
    chk("t1_busy_low", busy, 1'b0);

    // back-to-back LOAD then ADD
    step(1'b1, 2'd0, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 32'd0);
    step(1'b1, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
    idle(2);
    chk("t2_hilo", {hi, lo}, 64'hFFFF_FFFF_0000_0001);
    chk("t2_wb2", wb_pulse, 1'b1);
    idle(1);

    // SUB wrap from zero
    step(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd0);
    step(1'b1, 2'd2, 32'd1, 32'd1, 1'b0, 1'b0, 32'd0);
    idle(2);
    chk("t3_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t3_ovf", ovf, 1'b0);

`ifdef MULHILO_OVF_EN
    // signed overflow on ADD, cleared by LOAD
    step(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h7FFF_FFFF);
    step(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    step(1'b1, 2'd1, 32'd1, 32'd1, 1'b0, 1'b0, 32'd0);
    idle(2);
    chk("t4_hi", hi, 64'h8000_0000);
    chk("t4_lo", lo, 64'd0);
    chk("t4_ovf", ovf, 1'b1);
    step(1'b1, 2'd0, 32'd2, 32'd2, 1'b0, 1'b0, 32'd0);
    idle(2);
    chk("t4_ovf_clr", ovf, 1'b0);
    chk("t4_lo4", lo, 64'd4);
`else
    // MTHI colliding with a LOAD write-back
    step(1'b1, 2'd0, 32'h12, 32'd1, 1'b0, 1'b0, 32'd0);
    idle(1);
    step(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    chk("t5_hi", hi, 64'd0);
    chk("t5_lo", lo, 64'h12);
    idle(1);
`endif

    // reset with a product in flight
    step(1'b1, 2'd0, 32'd7, 32'd9, 1'b0, 1'b0, 32'd0);
    do_reset();
    idle(3);
    chk("t6_hilo", {hi, lo}, 64'd0);
    chk("t6_wb", wb_pulse, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6) begin
        step(1'b1, 2'($urandom_range(0, 3)),
             (r == 0) ? 32'hFFFF_FFFF : $urandom(), $urandom(),
             1'b0, 1'b0, 32'd0);
      end else if (r == 9 && pq.size() == 0) begin
        step(1'b0, 2'd0, 32'd0, 32'd0, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom());
      end else begin
        idle(1);
      end
    end
    idle(L + 1);
    chk("drain_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
